// File: rtl/uart_result_tx.sv
// uart_result_tx: serialises a snapshot of a 32-bit ALU result and 5 flags
// as one 8N1 UART frame: header, four result bytes (MSB first), flags byte.
// Optional feature macro: UART_TX_CHECKSUM_EN appends an XOR checksum byte
// (result bytes and flags byte, header excluded), giving 7 bytes instead of 6.
module uart_result_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_send,
   input  logic [15:0] i_result_high,
   input  logic [15:0] i_result_low,
   input  logic [4:0]  i_flags,
   output logic        o_tx,
   output logic        o_busy,
   output logic        o_done
);

`ifdef UART_TX_CHECKSUM_EN
   localparam logic [2:0] LP_LAST_BYTE = 3'd6;
`else
   localparam logic [2:0] LP_LAST_BYTE = 3'd5;
`endif
   localparam logic [15:0] LP_LAST_CNT = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

`ifdef UART_TX_CHECKSUM_EN
   function automatic logic [7:0] f_checksum(input logic [31:0] res, input logic [4:0] flags);
      return res[31:24] ^ res[23:16] ^ res[15:8] ^ res[7:0] ^ {3'b000, flags};
   endfunction
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [2:0]  r_bit_idx;
   logic [2:0]  w_bit_nxt;
   logic [2:0]  r_byte_idx;
   logic [2:0]  w_byte_nxt;
   logic [31:0] r_snap_result;
   logic [4:0]  r_snap_flags;
   logic        w_snap_load;
   logic        w_tx_nxt;
   logic        w_busy_nxt;
   logic        w_done_nxt;
   logic [7:0]  w_byte;

   // Select the byte currently being serialised from the snapshot.
   always_comb begin
      w_byte = 8'h00;
      case (r_byte_idx)
         3'd0:    w_byte = HEADER_BYTE;
         3'd1:    w_byte = r_snap_result[31:24];
         3'd2:    w_byte = r_snap_result[23:16];
         3'd3:    w_byte = r_snap_result[15:8];
         3'd4:    w_byte = r_snap_result[7:0];
         3'd5:    w_byte = {3'b000, r_snap_flags};
`ifdef UART_TX_CHECKSUM_EN
         3'd6:    w_byte = f_checksum(r_snap_result, r_snap_flags);
`endif
         default: w_byte = 8'h00;
      endcase
   end

   // Next-state, counter and output decode; outputs are registered from these.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_byte_nxt  = r_byte_idx;
      w_snap_load = 1'b0;
      w_done_nxt  = 1'b0;
      w_tx_nxt    = 1'b1;
      w_busy_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A request in the o_done cycle is dropped so frames never merge.
            if (i_send && !o_done) begin
               w_state_nxt = ST_START;
               w_cnt_nxt   = 16'd0;
               w_bit_nxt   = 3'd0;
               w_byte_nxt  = 3'd0;
               w_snap_load = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            if (r_cnt == LP_LAST_CNT) begin
               w_state_nxt = ST_DATA;
               w_cnt_nxt   = 16'd0;
               w_bit_nxt   = 3'd0;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         ST_DATA: begin
            if (r_cnt == LP_LAST_CNT) begin
               w_cnt_nxt = 16'd0;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         ST_STOP: begin
            if (r_cnt == LP_LAST_CNT) begin
               w_cnt_nxt = 16'd0;
               if (r_byte_idx == LP_LAST_BYTE) begin
                  w_state_nxt = ST_IDLE;
                  w_byte_nxt  = 3'd0;
                  w_done_nxt  = 1'b1;
               end else begin
                  // Next start bit follows the stop bit with no idle gap.
                  w_state_nxt = ST_START;
                  w_byte_nxt  = r_byte_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 16'd0;
            w_bit_nxt   = 3'd0;
            w_byte_nxt  = 3'd0;
         end
      endcase
      // Line level for the coming cycle follows the state being entered.
      case (w_state_nxt)
         ST_START: w_tx_nxt = 1'b0;
         ST_DATA:  w_tx_nxt = w_byte[w_bit_nxt];
         ST_STOP:  w_tx_nxt = 1'b1;
         default:  w_tx_nxt = 1'b1;
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bit-period counter, bit/byte indices and registered line outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= 16'd0;
         r_bit_idx  <= 3'd0;
         r_byte_idx <= 3'd0;
         o_tx       <= 1'b1;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_byte_idx <= w_byte_nxt;
         o_tx       <= w_tx_nxt;
         o_busy     <= w_busy_nxt;
         o_done     <= w_done_nxt;
      end
   end

   // Snapshot of result and flags, captured only when a frame is accepted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_snap_result <= 32'd0;
         r_snap_flags  <= 5'd0;
      end else if (w_snap_load) begin
         r_snap_result <= {i_result_high, i_result_low};
         r_snap_flags  <= i_flags;
      end
   end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: randomized self-checking bench for uart_result_tx.
// The reference frame is built from the byte-order rule and the expected
// line level per cycle is derived arithmetically from bit period and position.
module tb_uart_result_tx;
   localparam int C = 4;
`ifdef UART_TX_CHECKSUM_EN
   localparam int NB = 7;
`else
   localparam int NB = 6;
`endif
   localparam int FRAME = NB * 10 * C;

   logic        clk = 1'b0;
   logic        rst;
   logic        send;
   logic [15:0] rh;
   logic [15:0] rl;
   logic [4:0]  fl;
   logic        tx;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic       obs[$];
   int         done_idx;
   int         busy_low;
   logic       done_tx;
   logic       done_busy;

   always #5 clk = ~clk;

   uart_result_tx #(.CLKS_PER_BIT(C), .HEADER_BYTE(8'hA5)) dut (
      .i_clk(clk), .i_rst(rst), .i_send(send),
      .i_result_high(rh), .i_result_low(rl), .i_flags(fl),
      .o_tx(tx), .o_busy(busy), .o_done(done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Expected frame bytes from the byte-order rule.
   task automatic build_exp(input logic [31:0] res, input logic [4:0] f);
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) exp_q.push_back(8'((res >> (8 * i)) & 32'hFF));
      exp_q.push_back({3'b000, f});
`ifdef UART_TX_CHECKSUM_EN
      begin
         logic [7:0] ck;
         ck = 8'h00;
         for (int i = 1; i < 6; i++) ck = ck ^ exp_q[i];
         exp_q.push_back(ck);
      end
`endif
   endtask

   task automatic send_pulse();
      @(posedge clk); #1 send = 1'b1;
      @(posedge clk); #1 send = 1'b0;
   endtask

   // Record the line each cycle after the accepting edge until o_done (bounded).
   task automatic capture(input int chg_at);
      obs.delete();
      done_idx  = -1;
      busy_low  = 0;
      done_tx   = 1'b0;
      done_busy = 1'b1;
      for (int k = 0; k < FRAME + 50; k++) begin
         @(negedge clk);
         if (k == chg_at) begin
            rh = 16'hFFFF; rl = 16'hFFFF; fl = 5'h1F; send = 1'b1;
         end else begin
            send = 1'b0;
         end
         if (done) begin
            done_idx  = k;
            done_tx   = tx;
            done_busy = busy;
            break;
         end
         obs.push_back(tx);
         if (!busy) busy_low++;
      end
   endtask

   task automatic verify(input string tag);
      int         mism;
      int         i;
      int         p;
      int         idx;
      logic [7:0] b;
      logic       e;
      logic [7:0] got;
      mism = 0;
      check({tag, "_done_at"}, 32'(done_idx), 32'(FRAME));
      check({tag, "_done_tx"}, 32'(done_tx), 32'd1);
      check({tag, "_done_busy"}, 32'(done_busy), 32'd0);
      check({tag, "_busy_low"}, 32'(busy_low), 32'd0);
      for (int k = 0; k < obs.size(); k++) begin
         i = k / (10 * C);
         p = (k % (10 * C)) / C;
         if (i < NB) begin
            b = exp_q[i];
            if (p == 0) e = 1'b0;
            else if (p == 9) e = 1'b1;
            else e = b[p-1];
            if (obs[k] !== e) mism++;
         end
      end
      check({tag, "_wave"}, 32'(mism), 32'd0);
      for (int n = 0; n < NB; n++) begin
         got = 8'h00;
         for (int j = 0; j < 8; j++) begin
            idx = n * 10 * C + (1 + j) * C + C / 2;
            if (idx < obs.size()) got[j] = obs[idx];
         end
         check({tag, "_byte"}, 32'(got), 32'(exp_q[n]));
      end
   endtask

   initial begin
      int extra;
      rst = 1'b1; send = 1'b0; rh = 16'h0; rl = 16'h0; fl = 5'h0;
      repeat (3) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Directed frame with known bytes.
      rh = 16'h1234; rl = 16'h5678; fl = 5'b10101;
      build_exp(32'h12345678, 5'b10101);
      send_pulse();
      capture(-1);
      verify("basic");

      // Inputs change and a second request arrives mid-frame.
      rh = 16'h1234; rl = 16'h5678; fl = 5'b10101;
      build_exp(32'h12345678, 5'b10101);
      send_pulse();
      capture(50);
      verify("ignore");
      extra = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("ignore_extra_done", 32'(extra), 32'd0);
      check("ignore_idle_busy", 32'(busy), 32'd0);
      check("ignore_idle_tx", 32'(tx), 32'd1);

      // Request in the o_done cycle is dropped; the next cycle's is taken.
      rh = 16'(($urandom)); rl = 16'(($urandom)); fl = 5'($urandom);
      build_exp({rh, rl}, fl);
      send_pulse();
      capture(-1);
      verify("pre_b2b");
      rh = 16'(($urandom)); rl = 16'(($urandom)); fl = 5'($urandom);
      build_exp({rh, rl}, fl);
      send = 1'b1;
      @(negedge clk);
      check("b2b_ign_busy", 32'(busy), 32'd0);
      check("b2b_ign_tx", 32'(tx), 32'd1);
      @(posedge clk); #1 send = 1'b0;
      capture(-1);
      verify("b2b");

      // Reset mid-frame aborts without o_done.
      rh = 16'hCAFE; rl = 16'hBEEF; fl = 5'h0A;
      send_pulse();
      extra = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_tx", 32'(tx), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) extra++;
      end
      check("abort_no_done", 32'(extra), 32'd0);
      build_exp({rh, rl}, fl);
      send_pulse();
      capture(-1);
      verify("after_rst");

      // All-zero payload.
      rh = 16'h0; rl = 16'h0; fl = 5'h0;
      build_exp(32'h0, 5'h0);
      send_pulse();
      capture(-1);
      verify("zeros");

      // Randomized frames with random idle gaps and random mid-frame disturbance.
      for (int r = 0; r < 8; r++) begin
         rh = 16'($urandom); rl = 16'($urandom); fl = 5'($urandom);
         build_exp({rh, rl}, fl);
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send_pulse();
         capture(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, FRAME - 1)));
         verify("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_result_tx.md
UART_RESULT_TX -- requirements
Module: uart_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, i_clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter HEADER_BYTE, default 8'hA5, first byte of every frame.
REQ-003 i_clk  input  1  system clock, all logic on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_send  input  1  single-cycle request to transmit one result frame.
REQ-006 i_result_high  input  16  upper half of 32-bit ALU result.
REQ-007 i_result_low  input  16  lower half of 32-bit ALU result.
REQ-008 i_flags  input  5  ALU flags.
REQ-009 o_tx  output  1  UART serial line, idle high.
REQ-010 o_busy  output  1  high while a frame is in progress.
REQ-011 o_done  output  1  single-cycle pulse when the frame's last stop bit completes.

Function
REQ-012 Line format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-013 Frame byte order SHALL be HEADER_BYTE, result[31:24], result[23:16], result[15:8], result[7:0], {3'b000, i_flags}, where result = {i_result_high, i_result_low}.
REQ-014 On the cycle i_send is sampled high with o_busy low, the block SHALL latch result and flags into a snapshot register; later input changes SHALL NOT affect the frame.
REQ-015 o_tx SHALL fall to the start bit and o_busy SHALL rise on the clock edge that samples the accepted i_send (1-cycle latency).
REQ-016 i_send while o_busy is high SHALL be ignored, with no queuing.
REQ-017 States SHALL be IDLE, START, DATA, STOP: IDLE->START on accepted i_send; START->DATA after CLKS_PER_BIT; DATA->STOP after 8 bit periods; STOP->START when bytes remain, otherwise STOP->IDLE.
REQ-018 Bytes SHALL be sent back-to-back with no idle gap between one stop bit and the next start bit.
REQ-019 The bit-period counter and 3-bit bit index SHALL count 0..CLKS_PER_BIT-1 and 0..7; the byte index SHALL count 0..N-1, where N is the frame length.
REQ-020 o_done SHALL pulse on the same edge that returns the state to IDLE; o_busy SHALL fall on that same edge.
REQ-021 An i_send in the cycle o_done is high SHALL be ignored; the earliest accepted i_send SHALL be one cycle after o_done.
REQ-022 Total frame duration SHALL be N*10*CLKS_PER_BIT cycles, measured from start-bit fall to o_done.

Reset
REQ-023 While i_rst is high: o_tx=1, o_busy=0, o_done=0, state IDLE, all counters and snapshot registers 0.
REQ-024 Asserting i_rst mid-frame SHALL abort the frame immediately (asynchronously) without an o_done pulse; the line SHALL return high.
REQ-025 After i_rst deasserts, the first i_send SHALL start a complete new frame from HEADER_BYTE.

Configuration
REQ-026 Macro UART_TX_CHECKSUM_EN defined: a seventh byte SHALL be appended, equal to the XOR of the four result bytes and the flags byte (header excluded), so N=7.
REQ-027 Macro UART_TX_CHECKSUM_EN undefined: no checksum logic SHALL exist and N=6.

Verification (all scenarios with CLKS_PER_BIT=4)
REQ-028 Set result=32'h12345678, flags=5'b10101, pulse i_send -> bytes A5 12 34 56 78 15 on o_tx, o_done exactly 240 cycles after start-bit fall; with macro, extra byte 1D and o_done at 280 cycles.
REQ-029 Pulse i_send, then change the inputs to 32'hFFFFFFFF and pulse i_send again at cycle 50 -> the frame still carries 12 34 56 78, the second request is ignored, and there is exactly one o_done.
REQ-030 Assert i_rst at cycle 100 of a frame -> o_tx=1 and o_busy=0 with no clock edge; no o_done; the next i_send produces a full frame starting with A5.
REQ-031 Pulse i_send in the o_done cycle, then again one cycle later -> the first is ignored; the second starts a frame 1 cycle after it is sampled.
REQ-032 Set result=0, flags=0 -> bytes A5 00 00 00 00 00 (checksum 00 with macro), with each stop bit high for exactly 4 cycles and no inter-byte gap.
